// File: rtl/nf_fetch_unit.sv
// rtl/nf_fetch_unit.sv - nanoFOX instruction fetch unit; `define NF_FETCH_BUF2_EN for a two-entry buffer
module nf_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_b_en,
    input  logic [31:0] pc_branch,
    output logic [31:0] addr_i,
    output logic        req_i,
    input  logic        ack_i,
    input  logic [31:0] rd_i,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

`ifdef NF_FETCH_BUF2_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] target;
    logic [1:0]  cnt;
    logic [1:0]  cnt_nxt;
    logic        push;
    logic        pop;
    logic [31:0] e0_data;
    logic [31:0] e0_pc;
`ifdef NF_FETCH_BUF2_EN
    logic [31:0] e1_data;
    logic [31:0] e1_pc;
`endif

    // Masking keeps every target bit in the expression; the low two are always cleared.
    assign target      = pc_branch & 32'hFFFF_FFFC;
    assign addr_i      = pc;
    // Only the FSM state (plus reset) decides the request, never ack/ready/branch inputs.
    assign req_i       = (state != S_IDLE) && !rst;
    // Data acked while discarding or in a branch cycle never enters the buffer.
    assign push        = (state == S_FETCH) && ack_i && !pc_b_en;
    assign pop         = instr_valid && instr_ready;
    assign instr_valid = (cnt != 2'd0);
    assign instr       = e0_data;
    assign instr_pc    = e0_pc;

    // Next buffer occupancy; a branch empties the buffer and overrides any pop.
    always_comb begin
        cnt_nxt = cnt;
        if (pc_b_en) begin
            cnt_nxt = 2'd0;
        end else if (push && !pop) begin
            cnt_nxt = cnt + 2'd1;
        end else if (pop && !push) begin
            cnt_nxt = cnt - 2'd1;
        end
    end

    // Fetch FSM and PC: PC is the next fetch address, tgt parks a redirect while an old fetch drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            tgt   <= RESET_PC;
        end else if (pc_b_en) begin
            if ((state != S_IDLE) && !ack_i) begin
                state <= S_DISCARD;
                tgt   <= target;
            end else begin
                state <= S_FETCH;
                pc    <= target;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (ack_i) begin
                        pc <= pc + 32'd4;
                    end
                    state <= (cnt_nxt == DEPTH) ? S_IDLE : S_FETCH;
                end
                S_IDLE: begin
                    if (cnt_nxt != DEPTH) begin
                        state <= S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (ack_i) begin
                        pc    <= tgt;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Instruction buffer: entry 0 is the head seen by decode; occupancy follows cnt_nxt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 2'd0;
            e0_data <= 32'd0;
            e0_pc   <= 32'd0;
`ifdef NF_FETCH_BUF2_EN
            e1_data <= 32'd0;
            e1_pc   <= 32'd0;
`endif
        end else begin
            cnt <= cnt_nxt;
`ifdef NF_FETCH_BUF2_EN
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        e0_data <= rd_i;
                        e0_pc   <= pc;
                    end else begin
                        e1_data <= rd_i;
                        e1_pc   <= pc;
                    end
                end
                2'b01: begin
                    e0_data <= e1_data;
                    e0_pc   <= e1_pc;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        e0_data <= rd_i;
                        e0_pc   <= pc;
                    end else begin
                        e0_data <= e1_data;
                        e0_pc   <= e1_pc;
                        e1_data <= rd_i;
                        e1_pc   <= pc;
                    end
                end
                default: ;
            endcase
`else
            if (push) begin
                e0_data <= rd_i;
                e0_pc   <= pc;
            end
`endif
        end
    end

endmodule

// File: tb/tb_nf_fetch_unit.sv
// tb/tb_nf_fetch_unit.sv - self-checking bench for nf_fetch_unit
module tb_nf_fetch_unit;

`ifdef NF_FETCH_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_b_en = 1'b0;
    logic [31:0] pc_branch = 32'd0;
    logic [31:0] addr_i;
    logic        req_i;
    logic        ack_i;
    logic [31:0] rd_i;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        ack_en = 1'b0;
    logic        ack_any = 1'b0;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    assign ack_i = ack_en && (req_i || ack_any);
    assign rd_i  = mem_word(addr_i);

    nf_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_b_en     (pc_b_en),
        .pc_branch   (pc_branch),
        .addr_i      (addr_i),
        .req_i       (req_i),
        .ack_i       (ack_i),
        .rd_i        (rd_i),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pc_b_en = 1'b0; ack_en = 1'b0; ack_any = 1'b0; instr_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_b_en = 1'b0; ack_en = 1'b1; instr_ready = 1'b1;
        tick();
        tick();
        checks++; if (req_i !== 1'b0) begin failures++; $display("FAIL reset_req: got %0b want 0", req_i); end
        checks++; if (addr_i !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", addr_i); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        rst = 1'b0;
        #1;
        checks++; if (req_i !== 1'b1 || addr_i !== 32'h0) begin failures++; $display("FAIL reset_first_req: got req=%0b addr=%h want req=1 addr=0", req_i, addr_i); end
    endtask

    task automatic test_reset_fetch();
        int          nfetch;
        logic        have_prev;
        logic [31:0] prev_addr;
        do_reset();
        ack_en = 1'b1; instr_ready = 1'b1;
        #1;
        nfetch = 0; have_prev = 1'b0; prev_addr = 32'h0;
        for (int c = 0; c < 8; c++) begin
            if (have_prev) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== prev_addr || instr !== mem_word(prev_addr)) begin
                    failures++; $display("FAIL fetch_follow c=%0d: got v=%0b pc=%h ins=%h want v=1 pc=%h ins=%h", c, instr_valid, instr_pc, instr, prev_addr, mem_word(prev_addr));
                end
            end
`ifdef NF_FETCH_BUF2_EN
            if (c >= 1) begin
                checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL fetch_full_rate c=%0d: got valid=%0b want 1", c, instr_valid); end
            end
`endif
            have_prev = req_i && ack_en;
            prev_addr = addr_i;
            if (have_prev) begin
                checks++;
                if (addr_i !== 32'(nfetch * 4)) begin failures++; $display("FAIL fetch_addr_seq n=%0d: got %h want %h", nfetch, addr_i, 32'(nfetch * 4)); end
                nfetch++;
            end
            tick();
        end
        checks++; if (nfetch < 4) begin failures++; $display("FAIL fetch_count: got %0d want >=4", nfetch); end
    endtask

    task automatic test_backpressure();
        int          nfetch;
        logic [31:0] exp_pc;
        do_reset();
        ack_en = 1'b1; instr_ready = 1'b0;
        nfetch = 0;
        for (int c = 0; c < 5; c++) begin
            if (req_i) nfetch++;
            if (c >= DEPTH) begin
                checks++; if (req_i !== 1'b0) begin failures++; $display("FAIL bp_req_drop c=%0d: got %0b want 0", c, req_i); end
            end
            if (c >= 1) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin
                    failures++; $display("FAIL bp_head_stable c=%0d: got v=%0b pc=%h ins=%h want v=1 pc=0 ins=%h", c, instr_valid, instr_pc, instr, mem_word(32'h0));
                end
            end
            tick();
        end
        checks++; if (nfetch != DEPTH) begin failures++; $display("FAIL bp_held_entries: got %0d want %0d", nfetch, DEPTH); end
        instr_ready = 1'b1;
        exp_pc = 32'h0;
        for (int c = 0; c < 12; c++) begin
            if (instr_valid) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                    failures++; $display("FAIL bp_drain_order: got pc=%h ins=%h want pc=%h ins=%h", instr_pc, instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            tick();
        end
        checks++; if (exp_pc < 32'd16) begin failures++; $display("FAIL bp_drain_progress: got next pc %h want >= 10", exp_pc); end
    endtask

    task automatic test_branch_no_pending();
        do_reset();
        ack_en = 1'b1; instr_ready = 1'b1;
        tick(); tick(); tick();
        pc_b_en = 1'b1; pc_branch = 32'h0000_0103;
        tick();
        pc_b_en = 1'b0;
        checks++; if (addr_i !== 32'h100 || req_i !== 1'b1) begin failures++; $display("FAIL br_addr_n1: got addr=%h req=%0b want 100/1", addr_i, req_i); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL br_flush_n1: got valid=%0b want 0", instr_valid); end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin
            failures++; $display("FAIL br_target_n2: got v=%0b pc=%h ins=%h want v=1 pc=100 ins=%h", instr_valid, instr_pc, instr, mem_word(32'h100));
        end
    endtask

    task automatic test_branch_wait();
        do_reset();
        ack_en = 1'b0; instr_ready = 1'b1;
        checks++; if (req_i !== 1'b1 || addr_i !== 32'h0) begin failures++; $display("FAIL bw_req_rise: got req=%0b addr=%h want 1/0", req_i, addr_i); end
        tick();
        pc_b_en = 1'b1; pc_branch = 32'h200;
        tick();
        pc_b_en = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            checks++;
            if (req_i !== 1'b1 || addr_i !== 32'h0 || instr_valid !== 1'b0) begin
                failures++; $display("FAIL bw_hold c=%0d: got req=%0b addr=%h v=%0b want 1/0/0", c, req_i, addr_i, instr_valid);
            end
            if (c == 3) ack_en = 1'b1;
            tick();
        end
        ack_en = 1'b0;
        checks++;
        if (addr_i !== 32'h200 || req_i !== 1'b1 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL bw_target: got addr=%h req=%0b v=%0b want 200/1/0", addr_i, req_i, instr_valid);
        end
        ack_en = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== mem_word(32'h200)) begin
            failures++; $display("FAIL bw_first_instr: got v=%0b pc=%h ins=%h want 1/200/%h", instr_valid, instr_pc, instr, mem_word(32'h200));
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_pc;
        do_reset();
        ack_en = 1'b1; instr_ready = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL sim_pre_valid: got %0b want 1", instr_valid); end
        pc_b_en = 1'b1; pc_branch = 32'h400;
        tick();
        pc_b_en = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL sim_flush: got valid=%0b want 0", instr_valid); end
        exp_pc = 32'h400;
        for (int c = 0; c < 8; c++) begin
            if (instr_valid) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                    failures++; $display("FAIL sim_stream: got pc=%h ins=%h want pc=%h", instr_pc, instr, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
            end
            tick();
        end
        checks++; if (exp_pc == 32'h400) begin failures++; $display("FAIL sim_progress: got no instruction want >=1"); end
        do_reset();
        ack_en = 1'b0; instr_ready = 1'b1;
        tick();
        pc_b_en = 1'b1; pc_branch = 32'h200;
        tick();
        pc_branch = 32'h300;
        tick();
        pc_b_en = 1'b0;
        checks++; if (req_i !== 1'b1 || addr_i !== 32'h0) begin failures++; $display("FAIL sim_discard_hold: got req=%0b addr=%h want 1/0", req_i, addr_i); end
        ack_en = 1'b1;
        tick();
        checks++; if (addr_i !== 32'h300 || req_i !== 1'b1) begin failures++; $display("FAIL sim_second_target: got addr=%h req=%0b want 300/1", addr_i, req_i); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h300) begin failures++; $display("FAIL sim_second_instr: got v=%0b pc=%h want 1/300", instr_valid, instr_pc); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        ack_en = 1'b1; instr_ready = 1'b1;
        tick(); tick(); tick(); tick();
        ack_en = 1'b0;
        for (int c = 0; c < 3 && req_i !== 1'b1; c++) tick();
        checks++; if (req_i !== 1'b1 || addr_i == 32'h0) begin failures++; $display("FAIL rmf_pending: got req=%0b addr=%h want 1/nonzero", req_i, addr_i); end
        rst = 1'b1;
        #1;
        checks++;
        if (req_i !== 1'b0 || addr_i !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            failures++; $display("FAIL rmf_async: got req=%0b addr=%h v=%0b ins=%h pc=%h want all 0", req_i, addr_i, instr_valid, instr, instr_pc);
        end
        ack_en = 1'b1; ack_any = 1'b1;
        tick(); tick();
        checks++; if (instr_valid !== 1'b0 || addr_i !== 32'h0) begin failures++; $display("FAIL rmf_ack_in_reset: got v=%0b addr=%h want 0/0", instr_valid, addr_i); end
        ack_any = 1'b0; rst = 1'b0;
        #1;
        checks++; if (req_i !== 1'b1 || addr_i !== 32'h0) begin failures++; $display("FAIL rmf_restart: got req=%0b addr=%h want 1/0", req_i, addr_i); end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin
            failures++; $display("FAIL rmf_first_instr: got v=%0b pc=%h ins=%h want 1/0/%h", instr_valid, instr_pc, instr, mem_word(32'h0));
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic [31:0] prev_hpc;
        logic [31:0] prev_hd;
        logic        prev_hold;
        logic        prev_stall;
        logic        br;
        int          delivered;
        do_reset();
        exp_pc = 32'h0; delivered = 0; prev_hold = 1'b0; prev_stall = 1'b0;
        prev_addr = 32'h0; prev_hpc = 32'h0; prev_hd = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_hold) begin
                checks++;
                if (req_i !== 1'b1 || addr_i !== prev_addr) begin
                    failures++; $display("FAIL rnd_req_hold c=%0d: got req=%0b addr=%h want 1/%h", c, req_i, addr_i, prev_addr);
                end
            end
            if (prev_stall) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== prev_hpc || instr !== prev_hd) begin
                    failures++; $display("FAIL rnd_head_stable c=%0d: got v=%0b pc=%h ins=%h want 1/%h/%h", c, instr_valid, instr_pc, instr, prev_hpc, prev_hd);
                end
            end
            ack_en      = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            br          = ($urandom_range(0, 15) == 0);
            pc_b_en     = br;
            pc_branch   = $urandom;
            if (instr_valid && instr_ready && !br) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                    failures++; $display("FAIL rnd_stream c=%0d: got pc=%h ins=%h want pc=%h ins=%h", c, instr_pc, instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (br) exp_pc = pc_branch & 32'hFFFF_FFFC;
            prev_hold  = req_i && !ack_en;
            prev_addr  = addr_i;
            prev_stall = instr_valid && !instr_ready && !br;
            prev_hpc   = instr_pc;
            prev_hd    = instr;
            tick();
        end
        pc_b_en = 1'b0;
        checks++; if (delivered < 300) begin failures++; $display("FAIL rnd_progress: got %0d delivered want >=300", delivered); end
    endtask

    initial begin
        test_reset();
        test_reset_fetch();
        test_backpressure();
        test_branch_no_pending();
        test_branch_wait();
        test_simultaneous();
        test_reset_mid_fetch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nf_fetch_unit.md
# nf_fetch_unit

Instruction fetch unit for the nanoFOX pipeline and the consumer of the branch unit's `pc_b_en` decision. It owns the program counter and issues word fetches to instruction memory over a req/ack handshake. Fetched words are buffered and handed to decode over a valid/ready handshake. A taken branch flushes the buffer, discards any in-flight fetch and redirects the PC to the branch target.

## Interface
Parameters:
- `RESET_PC`, `32'h0000_0000`: PC value after reset; bits [1:0] must be zero.

Ports:
- `clk`  in  1  single clock; all state on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pc_b_en`  in  1  taken-branch pulse from the branch unit
- `pc_branch`  in  32  branch target; sampled only when `pc_b_en`=1; bits [1:0] ignored (forced 00)
- `addr_i`  out  32  instruction memory word address (byte address)
- `req_i`  out  1  fetch request
- `ack_i`  in  1  fetch acknowledge; `rd_i` valid in the ack cycle
- `rd_i`  in  32  instruction read data
- `instr`  out  32  instruction at buffer head
- `instr_pc`  out  32  PC of `instr`
- `instr_valid`  out  1  buffer head valid
- `instr_ready`  in  1  decode accepts head

## Operation
- The PC register holds the address of the next fetch. `addr_i` = PC.
- **Request rule:** `req_i`=1 iff buffer occupancy < DEPTH and the unit is not in reset.
  - Once raised, `req_i` and `addr_i` hold until the cycle with `ack_i`=1, even if the buffer or a branch would otherwise lower `req_i`.
  - Only one fetch is outstanding at a time.
- **Ack without branch:**
  - {`rd_i`, `addr_i`} is pushed into the buffer.
  - PC <= PC+4, wrapping 32'hFFFF_FFFC -> 0.
- **Buffer:** DEPTH-entry FIFO.
  - The head drives `instr`/`instr_pc`/`instr_valid`.
  - Pop when `instr_valid && instr_ready`.
  - Push and pop may occur in the same cycle.
  - `instr`/`instr_pc` hold stable while `instr_valid && !instr_ready`.
- **Taken branch:** `pc_b_en` has priority over every other event.
  - Buffer is cleared, so `instr_valid`=0 next cycle. A same-cycle pop is ignored.
  - PC <= {`pc_branch`[31:2], 2'b00}.
  - If `ack_i`=1 in the same cycle, that data is dropped.
  - If `req_i`=1 and `ack_i`=0, enter DISCARD:
    - `req_i` and the old `addr_i` stay held until ack.
    - The acked data is dropped.
    - The first target fetch is issued the cycle after that ack.
  - A new `pc_b_en` during DISCARD overwrites the target and stays in DISCARD.
- **FSM:**
  - IDLE (`req_i`=0, buffer full) <-> FETCH (`req_i`=1).
  - FETCH -> DISCARD on branch without ack.
  - DISCARD -> FETCH on `ack_i`.
  - Any state -> FETCH on branch when no fetch is pending.
- **Reset:** asynchronous, active at any time including mid-fetch. Outstanding fetch and buffer are abandoned. An ack arriving while `rst`=1 is ignored.

## Timing
- **Reset values:**
  - `req_i`=0, `addr_i`=`RESET_PC`
  - `instr_valid`=0, `instr`=0, `instr_pc`=0
  - FSM=FETCH pending, buffer empty
- The first `req_i`=1 is in the first cycle after `rst` deasserts.
- **Fetch latency:** ack in cycle N -> `instr_valid`=1 in N+1. The buffer is registered; there is no combinational path from `rd_i` to `instr`.
- **Branch latency** (`pc_b_en` in cycle N, no pending fetch, zero-wait memory):
  - `addr_i`=target in N+1.
  - Target instruction valid in N+2.
- **Throughput** (zero-wait memory, decode always ready):
  - DEPTH=2: one instruction per cycle.
  - DEPTH=1: one instruction per two cycles.
- `req_i` depends only on registered state. No combinational path exists from `ack_i`, `instr_ready` or `pc_b_en` to `req_i`/`addr_i`.

## Configuration
- `NF_FETCH_BUF2_EN` defined: DEPTH=2 (two-entry FIFO, full-rate fetch).
- Not defined: DEPTH=1 (single holding register). Fetch stalls while the entry is occupied. All other behaviour is identical.

## Test plan
- **Reset fetch:** `RESET_PC`=0, memory acks every request in the same cycle, `instr_ready`=1.
  - `addr_i` sequence 0,4,8,C.
  - `instr_pc` follows one cycle later.
  - With `NF_FETCH_BUF2_EN`, `instr_valid` stays 1 every cycle from cycle 2.
- **Backpressure:** `instr_ready`=0 for 5 cycles.
  - `req_i` drops once DEPTH entries are held.
  - Head `instr`/`instr_pc` stay stable.
  - On release, entries drain in order with no loss or duplicate.
- **Branch, no pending fetch:** `pc_b_en`=1, `pc_branch`=32'h0000_0103 in cycle N.
  - Buffer flushed.
  - `addr_i`=32'h0000_0100 in N+1.
  - `instr_pc`=32'h100 in N+2.
- **Branch during wait state:** memory delays ack by 3 cycles; branch to 32'h200 one cycle after `req_i` rises.
  - Old `addr_i` is held until ack.
  - Its data never appears on `instr`.
  - Next `addr_i`=32'h200.
- **Simultaneous events:**
  - Branch with ack and pop in the same cycle: no instruction from before the branch reaches decode after N.
  - Second branch to 32'h300 during DISCARD: the fetch after ack is 32'h300.
- **Reset mid-fetch:** assert `rst` while `req_i`=1 and `ack_i`=0.
  - Outputs take reset values immediately.
  - After release, fetch restarts at `RESET_PC`.
